// File: rtl/regfile_sb.sv
// Multi-port register file with per-entry busy scoreboard, pair-write port and flags register.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle writes (data and busy) to the read ports.
module regfile_sb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_req,
    output logic                     ready_o,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     pw_we,
    input  logic [DATA_W-1:0]        hi,
    input  logic [DATA_W-1:0]        lo,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        busy_o,
    input  logic                     iss_we,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     flags_we,
    input  logic [DATA_W-1:0]        flags_i,
    output logic [DATA_W-1:0]        flags_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] HI_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LO_ADDR = ADDR_W'(DEPTH - 2);

    typedef enum logic {StInit, StReady} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]    busy_q, busy_d;
    logic [DATA_W-1:0]   flags_q;
    logic                active;
    logic                wr_en;
    logic                pw_en;
    logic                iss_en;

    assign active = (state_q == StReady);
    assign wr_en  = active && we && (waddr != '0);
    assign pw_en  = active && pw_we;
    assign iss_en = active && iss_we && (iss_addr != '0);

    // Init sweep FSM; clr_req restarts the sweep from entry 0 in either state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StInit;
            cnt_q   <= '0;
            ready_o <= 1'b0;
        end else if (clr_req) begin
            state_q <= StInit;
            cnt_q   <= '0;
            ready_o <= 1'b0;
        end else begin
            case (state_q)
                StInit: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_q <= StReady;
                        ready_o <= 1'b1;
                    end
                end
                StReady: begin
                    state_q <= StReady;
                end
                default: begin
                    state_q <= StInit;
                    cnt_q   <= '0;
                    ready_o <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset: entries are only cleared by the sweep. Pair write is
    // issued last so it wins over a colliding main-port write.
    always_ff @(posedge clk) begin
        if (state_q == StInit) begin
            mem[cnt_q] <= '0;
        end
        if (wr_en) begin
            mem[waddr] <= wdata;
        end
        if (pw_en) begin
            mem[HI_ADDR] <= hi;
            mem[LO_ADDR] <= lo;
        end
    end

    // Writes retire a pending result; an issue in the same cycle takes priority.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[waddr] = 1'b0;
        end
        if (pw_en) begin
            busy_d[HI_ADDR] = 1'b0;
            busy_d[LO_ADDR] = 1'b0;
        end
        if (iss_en) begin
            busy_d[iss_addr] = 1'b1;
        end
        if (clr_req) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_q <= '0;
        end else if (active && flags_we) begin
            flags_q <= flags_i;
        end
    end

    assign flags_o = flags_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              hit;
        logic [DATA_W-1:0] val;
        logic              busy;

        assign addr = raddr[k*ADDR_W +: ADDR_W];
        assign hit  = active && re[k] && (addr != '0);

`ifdef REGFILE_SB_BYPASS_EN
        logic pw_hi_hit, pw_lo_hit, wr_hit, written, issued;

        assign pw_hi_hit = pw_en && (addr == HI_ADDR);
        assign pw_lo_hit = pw_en && (addr == LO_ADDR);
        assign wr_hit    = wr_en && (waddr == addr);
        assign written   = pw_hi_hit || pw_lo_hit || wr_hit;
        assign issued    = iss_en && (iss_addr == addr);

        always_comb begin
            if (!hit) begin
                val = '0;
            end else if (pw_hi_hit) begin
                val = hi;
            end else if (pw_lo_hit) begin
                val = lo;
            end else if (wr_hit) begin
                val = wdata;
            end else begin
                val = mem[addr];
            end
        end

        assign busy = hit && ((busy_q[addr] && !written) || issued);
`else
        assign val  = hit ? mem[addr] : '0;
        assign busy = hit && busy_q[addr];
`endif

        assign rdata[k*DATA_W +: DATA_W] = val;
        assign busy_o[k]                 = busy;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 32, register and flags data width in bits.
REQ-002 Parameter ADDR_W, default 5, register address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter NUM_RD, default 3, number of read ports (1..8).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset (0 = in reset).
REQ-006 clr_req  in  1  pulse; starts a re-initialisation sweep.
REQ-007 ready_o  out  1  high when the file is initialised and accepting writes.
REQ-008 we / waddr / wdata  in  1 / ADDR_W / DATA_W  main write port.
REQ-009 pw_we / hi / lo  in  1 / DATA_W / DATA_W  pair write to entries DEPTH-1 (hi) and DEPTH-2 (lo).
REQ-010 re  in  NUM_RD  per-port read enable.
REQ-011 raddr  in  NUM_RD*ADDR_W  packed read addresses; port k at [k*ADDR_W +: ADDR_W].
REQ-012 rdata  out  NUM_RD*DATA_W  packed read data; port k at [k*DATA_W +: DATA_W].
REQ-013 busy_o  out  NUM_RD  per-port flag: addressed entry has a write pending.
REQ-014 iss_we / iss_addr  in  1 / ADDR_W  marks an entry busy (result in flight).
REQ-015 flags_we / flags_i  in  1 / DATA_W  flags register write.
REQ-016 flags_o  out  DATA_W  current flags register value.

Function
REQ-017 States INIT and READY; INIT clears one entry per cycle, index counter 0..DEPTH-1, then READY.
REQ-018 INIT lasts exactly DEPTH cycles; ready_o rises the cycle after entry DEPTH-1 is cleared.
REQ-019 clr_req in READY -> INIT with counter 0; clr_req in INIT restarts the counter at 0.
REQ-020 In INIT: we, pw_we, iss_we, flags_we ignored; rdata all zero; busy_o all zero.
REQ-021 In READY: we=1 and waddr!=0 writes wdata to entry waddr at the clock edge; entry 0 never written.
REQ-022 pw_we=1 writes hi to DEPTH-1 and lo to DEPTH-2 in the same cycle.
REQ-023 we and pw_we targeting the same entry in one cycle: the pair-write value wins.
REQ-024 Read is combinational: re[k]=0 or raddr k = 0 -> rdata k = 0; else stored value of the entry.
REQ-025 Scoreboard: one busy bit per entry; iss_we sets bit iss_addr (ignored for address 0).
REQ-026 A write by we or pw_we clears the busy bit of every entry it writes.
REQ-027 Issue and write to the same entry in one cycle: busy ends set (issue wins).
REQ-028 busy_o[k] = re[k] AND busy bit of raddr k, subject to REQ-036.
REQ-029 flags_we=1 loads flags_i into the flags register; flags_o is registered, no bypass.
REQ-030 Any number of ports may read the same address in one cycle with identical results.

Reset
REQ-031 rst=0 immediately: state INIT, counter 0, ready_o 0, all busy bits 0, flags register 0.
REQ-032 rst=0 mid-sweep or mid-operation aborts it; a full DEPTH-cycle sweep follows rst release.
REQ-033 Entries are cleared only by the sweep, not by the asynchronous reset.

Configuration
REQ-034 Macro REGFILE_SB_BYPASS_EN selects same-cycle write-to-read forwarding.
REQ-035 Defined: in READY, a read of an entry written this cycle returns the new value (pair value if both).
REQ-036 Defined: busy_o is 0 for an entry written this cycle unless issued this cycle.
REQ-037 Undefined: reads return the pre-edge stored value; busy_o reflects the pre-edge busy bit.

Verification
REQ-038 Release rst; ready_o=0 for 32 cycles, then 1; all ports read 0 at addresses 1..31.
REQ-039 Write 0xDEADBEEF to r5, read r5 on port 2 next cycle -> 0xDEADBEEF; write r0=0x1234 -> read r0 = 0.
REQ-040 Same cycle we r31=0x1111 and pw_we hi=0xAAAA lo=0xBBBB -> r31=0xAAAA, r30=0xBBBB.
REQ-041 iss_we r7, then read r7 -> busy_o=1; write r7=0x42 -> next cycle busy_o=0, rdata=0x42; issue+write r7 same cycle -> busy stays 1.
REQ-042 With bypass: write r9=0x99 and read r9 same cycle -> 0x99; without bypass -> old value 0.
REQ-043 clr_req after filling r1..r31 with nonzero values -> ready_o low 32 cycles; afterwards all reads 0, busy 0.
